// File: rtl/light_pen_locator.sv
// Light-pen locator: pairs the synchronised pen photo-sensor with the LED scan
// coordinate that lit it, and reports which pixel the pen sits over.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   led_row, led_col   current scan pixel, one-hot each (all-zero = blank)
//   pen_in             raw asynchronous pen sensor, 1 = light seen
//   track_en           1 = locating enabled, 0 forces idle
//   hit_valid, pen_we  one-cycle pulse when the pen has been located
//   hit_row, hit_col   binary coordinate of the last hit (held)
//   pen_present        1 while the pen is being tracked
//   scan_err           sticky flag for a non-blank, non-one-hot scan pattern
module light_pen_locator #(
  parameter int unsigned PEN_DELAY    = 4,
  parameter int unsigned FILTER_LEN   = 3,
  parameter int unsigned LOST_TIMEOUT = 1000000,
  parameter int unsigned TIMEOUT_W    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] led_row,
  input  logic [7:0] led_col,
  input  logic       pen_in,
  input  logic       track_en,
  output logic       hit_valid,
  output logic [2:0] hit_row,
  output logic [2:0] hit_col,
  output logic       pen_we,
  output logic       pen_present,
  output logic       scan_err
);

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } coord_t;

  typedef enum logic [0:0] {StIdle, StTrack} state_e;

  // Registered coordinate plus PEN_DELAY-2 further stages.
  localparam int Stages = int'(PEN_DELAY) - 1;
  localparam logic [2:0] FilterMax = 3'(FILTER_LEN);
  localparam logic [TIMEOUT_W-1:0] LostMax = TIMEOUT_W'(LOST_TIMEOUT - 1);

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [2:0] bin_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  coord_t                 coord_in;
  logic                   coord_bad;
  logic                   sync1_q, sync2_q;
  coord_t                 pipe_q [Stages];
  coord_t                 prev_q;
  coord_t                 dcoord;
  logic                   new_pix;
  logic [2:0]             cnt_q, cnt_d;
  logic                   reported_q, reported_d;
  logic                   qualified;
  state_e                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   lost_q, lost_d;
  logic                   hit_valid_q;
  logic [2:0]             hit_row_q, hit_col_q;
  logic                   scan_err_q;

  // Encoder: invalid coordinates are zeroed so change detection only sees real pixels.
  always_comb begin
    coord_in.valid = is_onehot(led_row) && is_onehot(led_col);
    coord_in.row   = coord_in.valid ? bin_idx(led_row) : 3'd0;
    coord_in.col   = coord_in.valid ? bin_idx(led_col) : 3'd0;
    coord_bad      = !coord_in.valid && ((led_row != 8'd0) || (led_col != 8'd0));
  end

  assign dcoord  = pipe_q[Stages-1];
  assign new_pix = (dcoord != prev_q);

  // Filter: a new pixel always restarts the count, so a hit needs the pen to
  // stay lit while one pixel is held for more than FILTER_LEN cycles.
  always_comb begin
    cnt_d = '0;
    if (track_en && sync2_q && dcoord.valid && !new_pix) begin
      cnt_d = (cnt_q == FilterMax) ? cnt_q : cnt_q + 3'd1;
    end
    qualified  = track_en && (cnt_d == FilterMax) && !reported_q;
    reported_d = new_pix ? 1'b0 : (reported_q | qualified);
  end

  always_comb begin
    state_d = state_q;
    lost_d  = lost_q;
    unique case (state_q)
      StIdle: begin
        lost_d = '0;
        if (qualified) state_d = StTrack;
      end
      StTrack: begin
        if (qualified) begin
          lost_d = '0;
        end else if (lost_q == LostMax) begin
          state_d = StIdle;
          lost_d  = '0;
        end else begin
          lost_d = lost_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        lost_d  = '0;
      end
    endcase
    if (!track_en) begin
      state_d = StIdle;
      lost_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      lost_q  <= lost_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      for (int i = 0; i < Stages; i++) pipe_q[i] <= '0;
      prev_q      <= '0;
      cnt_q       <= '0;
      reported_q  <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_row_q   <= '0;
      hit_col_q   <= '0;
      scan_err_q  <= 1'b0;
    end else begin
      sync1_q     <= pen_in;
      sync2_q     <= sync1_q;
      pipe_q[0]   <= coord_in;
      for (int i = 1; i < Stages; i++) pipe_q[i] <= pipe_q[i-1];
      prev_q      <= dcoord;
      cnt_q       <= cnt_d;
      reported_q  <= reported_d;
      hit_valid_q <= qualified;
      if (qualified) begin
        hit_row_q <= dcoord.row;
        hit_col_q <= dcoord.col;
      end
      scan_err_q  <= scan_err_q | coord_bad;
    end
  end

  assign hit_valid   = hit_valid_q;
  assign pen_we      = hit_valid_q;
  assign hit_row     = hit_row_q;
  assign hit_col     = hit_col_q;
  assign pen_present = (state_q == StTrack);
  assign scan_err    = scan_err_q;

endmodule

// File: tb/tb_light_pen_locator.sv
// Self-checking bench for light_pen_locator: directed scenarios plus a random
// phase, every cycle compared against a history-based reference model.
module tb_light_pen_locator;

  localparam int unsigned PEN_DELAY    = 4;
  localparam int unsigned FILTER_LEN   = 3;
  localparam int unsigned LOST_TIMEOUT = 100;
  localparam int unsigned TIMEOUT_W    = 7;
  localparam int LightLag = int'(PEN_DELAY) - 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] led_row, led_col;
  logic       pen_in, track_en;
  logic       hit_valid, pen_we, pen_present, scan_err;
  logic [2:0] hit_row, hit_col;

  light_pen_locator #(
    .PEN_DELAY   (PEN_DELAY),
    .FILTER_LEN  (FILTER_LEN),
    .LOST_TIMEOUT(LOST_TIMEOUT),
    .TIMEOUT_W   (TIMEOUT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_row    (led_row),
    .led_col    (led_col),
    .pen_in     (pen_in),
    .track_en   (track_en),
    .hit_valid  (hit_valid),
    .hit_row    (hit_row),
    .hit_col    (hit_col),
    .pen_we     (pen_we),
    .pen_present(pen_present),
    .scan_err   (scan_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: per-edge history of scan keys and pen samples.
  int h_key[$];   // {valid, row, col} as an int, index 0 = newest
  bit h_pen[$];
  int m_cnt, m_n, m_last_hit;
  bit m_reported, m_track, m_hv, m_err;
  int m_hr, m_hc;
  bit light_q[$]; // sensor light, delayed by the external optical lag

  function automatic int key_at(input int k);
    return (k < h_key.size()) ? h_key[k] : 0;
  endfunction

  function automatic bit pen_at(input int k);
    return (k < h_pen.size()) ? h_pen[k] : 1'b0;
  endfunction

  task automatic model_reset();
    h_key.delete(); h_pen.delete();
    m_cnt = 0; m_n = 0; m_last_hit = 0;
    m_reported = 0; m_track = 0; m_hv = 0; m_err = 0; m_hr = 0; m_hc = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic [7:0] c, input logic p,
                            input logic en);
    int key, kd, kp;
    bit v, ps, qual;
    v   = ($countones(r) == 1) && ($countones(c) == 1);
    key = v ? (64 + 8 * $clog2(r) + $clog2(c)) : 0;
    if (!v && (r != 8'd0 || c != 8'd0)) m_err = 1;
    h_key.push_front(key);
    h_pen.push_front(p);
    while (h_key.size() > int'(PEN_DELAY) + 1) void'(h_key.pop_back());
    while (h_pen.size() > 3) void'(h_pen.pop_back());
    ps = pen_at(2);                    // pen after the 2-flop synchroniser
    kd = key_at(int'(PEN_DELAY) - 1);  // delayed coordinate this cycle
    kp = key_at(int'(PEN_DELAY));      // delayed coordinate last cycle
    if (en && ps && kd >= 64 && kd == kp) m_cnt = (m_cnt < FILTER_LEN) ? m_cnt + 1 : m_cnt;
    else m_cnt = 0;
    qual = en && (m_cnt == FILTER_LEN) && !m_reported;
    if (kd != kp) m_reported = 0;
    else if (qual) m_reported = 1;
    m_hv = qual;
    if (qual) begin
      m_hr = (kd / 8) % 8;
      m_hc = kd % 8;
    end
    if (!en) m_track = 0;
    else if (qual) begin
      m_track = 1;
      m_last_hit = m_n;
    end else if (m_track && (m_n - m_last_hit) == int'(LOST_TIMEOUT)) m_track = 0;
    m_n++;
  endtask

  int tb_cyc = 0;
  int hits, hits_tgt, hits_nb, last_hit_cyc, last_r, last_c;
  bit pres_at_hit;

  task automatic zero_stats();
    hits = 0; hits_tgt = 0; hits_nb = 0; last_r = 0; last_c = 0; pres_at_hit = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(led_row, led_col, pen_in, track_en);
    #1;
    tb_cyc++;
    check("hit_valid", int'(hit_valid), int'(m_hv));
    check("pen_we", int'(pen_we), int'(m_hv));
    check("hit_row", int'(hit_row), m_hr);
    check("hit_col", int'(hit_col), m_hc);
    check("pen_present", int'(pen_present), int'(m_track));
    check("scan_err", int'(scan_err), int'(m_err));
    if (hit_valid) begin
      hits++;
      if (hit_row == 3'd7 && hit_col == 3'd0) hits_tgt++;
      if ((hit_row == 3'd6 && hit_col == 3'd0) || (hit_row == 3'd7 && hit_col == 3'd1))
        hits_nb++;
      last_hit_cyc = tb_cyc;
      last_r = int'(hit_row);
      last_c = int'(hit_col);
      pres_at_hit = pen_present;
    end
  endtask

  function automatic logic [7:0] px(input int i);
    logic [7:0] v;
    v = 8'd1 << i;
    return v;
  endfunction

  task automatic apply(input logic [7:0] r, input logic [7:0] c, input bit light,
                       input bit en);
    led_row = r;
    led_col = c;
    track_en = en;
    light_q.push_back(light);
    if (light_q.size() > LightLag) pen_in = light_q.pop_front();
    else pen_in = 1'b0;
    tick();
  endtask

  task automatic blank(input int n, input bit light, input bit en);
    for (int i = 0; i < n; i++) apply(8'd0, 8'd0, light, en);
  endtask

  task automatic do_reset();
    led_row = 8'd0; led_col = 8'd0; pen_in = 1'b0; track_en = 1'b1;
    light_q.delete();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  int k, seg, dwell, sel, tr, tc;
  bit aligned, en_r, tgt;
  logic [7:0] rr, cc;

  initial begin
    rst_n = 1'b0; led_row = 8'd0; led_col = 8'd0; pen_in = 1'b0; track_en = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hit_valid", int'(hit_valid), 0);
    check("rst_pen_we", int'(pen_we), 0);
    check("rst_hit_row", int'(hit_row), 0);
    check("rst_hit_col", int'(hit_col), 0);
    check("rst_pen_present", int'(pen_present), 0);
    check("rst_scan_err", int'(scan_err), 0);
    rst_n = 1'b1;

    // 1: one pixel visit with aligned pen
    zero_stats();
    for (int i = 0; i < 8; i++) apply(px(3), px(5), 1'b1, 1'b1);
    blank(8, 1'b0, 1'b1);
    check("t1_hits", hits, 1);
    check("t1_row", last_r, 3);
    check("t1_col", last_c, 5);
    check("t1_present_with_hit", int'(pres_at_hit), 1);

    // 2: pen pulse too short for the filter
    do_reset();
    zero_stats();
    for (int i = 0; i < 8; i++) apply(px(3), px(5), (i == 3 || i == 4), 1'b1);
    blank(8, 1'b0, 1'b1);
    check("t2_hits", hits, 0);
    check("t2_present", int'(pen_present), 0);

    // 3: three full frames, pen over (7,0)
    do_reset();
    zero_stats();
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          for (int d = 0; d < 6; d++) apply(px(r), px(c), (r == 7 && c == 0), 1'b1);
    blank(8, 1'b0, 1'b1);
    check("t3_hits", hits, 3);
    check("t3_hits_target", hits_tgt, 3);
    check("t3_hits_neighbour", hits_nb, 0);

    // 4: pen lifted, lost timeout
    do_reset();
    zero_stats();
    for (int i = 0; i < 8; i++) apply(px(2), px(6), 1'b1, 1'b1);
    check("t4_hits", hits, 1);
    for (k = 0; k < 200 && pen_present; k++) apply(8'd0, 8'd0, 1'b0, 1'b1);
    check("t4_drop_delay", tb_cyc - last_hit_cyc, int'(LOST_TIMEOUT));
    check("t4_hold_row", int'(hit_row), 2);
    check("t4_hold_col", int'(hit_col), 6);

    // 5: blank is fine, malformed row sets the sticky error
    do_reset();
    zero_stats();
    blank(5, 1'b1, 1'b1);
    check("t5_blank_no_err", int'(scan_err), 0);
    apply(8'b0000_0011, px(2), 1'b1, 1'b1);
    check("t5_err_set", int'(scan_err), 1);
    blank(8, 1'b1, 1'b1);
    check("t5_err_sticky", int'(scan_err), 1);
    check("t5_hits", hits, 0);

    // 6: reset in the middle of a qualifying pulse, then track_en low
    do_reset();
    zero_stats();
    for (int i = 0; i < 9; i++) apply(px(4), px(4), 1'b1, 1'b1);
    check("t6_pre_hits", hits, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_hit_valid", int'(hit_valid), 0);
    check("t6_rst_pen_we", int'(pen_we), 0);
    check("t6_rst_hit_row", int'(hit_row), 0);
    check("t6_rst_hit_col", int'(hit_col), 0);
    check("t6_rst_present", int'(pen_present), 0);
    check("t6_rst_scan_err", int'(scan_err), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    zero_stats();
    apply(px(4), px(4), 1'b1, 1'b1);
    apply(px(4), px(4), 1'b1, 1'b1);
    blank(8, 1'b0, 1'b1);
    check("t6_stale_hits", hits, 0);
    for (int i = 0; i < 10; i++) apply(px(4), px(4), 1'b1, 1'b0);
    blank(6, 1'b0, 1'b0);
    check("t6_disabled_hits", hits, 0);
    check("t6_disabled_present", int'(pen_present), 0);

    // Random phase
    do_reset();
    tr = $urandom_range(0, 7);
    tc = $urandom_range(0, 7);
    for (seg = 0; seg < 80; seg++) begin
      dwell   = $urandom_range(1, 9);
      sel     = $urandom_range(0, 19);
      aligned = ($urandom_range(0, 3) != 0);
      en_r    = ($urandom_range(0, 9) != 0);
      if (sel == 0) begin
        rr = 8'($urandom_range(0, 255));
        cc = 8'($urandom_range(0, 255));
      end else if (sel == 1) begin
        rr = 8'd0;
        cc = 8'd0;
      end else if (sel < 10) begin
        rr = px(tr);
        cc = px(tc);
      end else begin
        rr = px($urandom_range(0, 7));
        cc = px($urandom_range(0, 7));
      end
      tgt = (rr == px(tr)) && (cc == px(tc));
      for (int d = 0; d < dwell; d++)
        apply(rr, cc, aligned ? tgt : bit'($urandom_range(0, 1)), en_r);
    end
    blank(8, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
